// File: rtl/edge_capture_fifo.sv
// Edge-triggered capture stage: combines request lines into a trigger, samples din on its
// rising edge into a small FIFO drained over a valid/ready port, and counts overflow drops.
module edge_capture_fifo #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic [N-1:0]               mask,
  input  logic [N-1:0]               req,
  input  logic [W-1:0]               din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic [CW-1:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          trig;
  logic          trig_q;
  logic          cap;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  always_comb begin
    trig = 1'b0;
    case (mode)
      2'b00: trig = |req;
      2'b01: trig = ~req[N-1] & (|req[N-2:0]);
      2'b10: trig = &req;
      2'b11: trig = |(req & mask);
      default: trig = 1'b0;
    endcase
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign full      = (count == (AW+1)'(DEPTH));
  assign cap       = trig & ~trig_q;
  assign pop       = out_valid & out_ready & ~clr;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign wr_en     = cap & ~clr & (~full | pop);
  assign drop      = cap & ~clr & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      trig_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      trig_q <= trig;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset: out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_edge_capture_fifo.sv
// Self-checking bench for edge_capture_fifo: vector table for trigger modes, reference
// model with a data scoreboard for overflow, wrap, clear and asynchronous reset sequences.
module tb_edge_capture_fifo;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] mask;
  logic [3:0] req;
  logic [7:0] din;
  logic       out_ready;

  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       ovf;
  logic [7:0] drop_cnt;

  logic       out_valid2;
  logic [7:0] out_data2;
  logic [2:0] count2;
  logic       ovf2;
  logic [1:0] drop_cnt2;

  int tests;
  int failures;

  // Reference model state; scoreboard queue holds expected FIFO contents in order
  logic [7:0] sb[$];
  logic       m_trig_q;
  logic       m_ovf;
  int         m_drop8;
  int         m_drop2;

  edge_capture_fifo #(.W(8), .N(4), .DEPTH(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .mask(mask), .req(req), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .ovf(ovf), .drop_cnt(drop_cnt)
  );

  edge_capture_fifo #(.W(8), .N(4), .DEPTH(4), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .mask(mask), .req(req), .din(din),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .count(count2),
    .ovf(ovf2), .drop_cnt(drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] mask;
    logic [3:0] req;
    logic [7:0] din;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_count;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[14];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_trig();
    case (mode)
      2'b00:   return req != 4'b0000;
      2'b01:   return (req[3] == 1'b0) && (req[2:0] != 3'b000);
      2'b10:   return req == 4'b1111;
      default: return (req & mask) != 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    m_trig_q = 1'b1;
    m_ovf    = 1'b0;
    m_drop8  = 0;
    m_drop2  = 0;
  endtask

  // Evaluated just before an active edge using the inputs that edge will see
  task automatic model_edge();
    logic t;
    logic cap;
    t   = model_trig();
    cap = t & ~m_trig_q;
    if (clr) begin
      model_reset();
    end else begin
      if (sb.size() != 0 && out_ready) begin
        cmp("pop_data", 32'(out_data), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (cap) begin
        if (sb.size() < 4) sb.push_back(din);
        else begin
          m_ovf = 1'b1;
          if (m_drop8 < 255) m_drop8++;
          if (m_drop2 < 3)   m_drop2++;
        end
      end
      m_trig_q = t;
    end
  endtask

  task automatic check_output();
    cmp("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    cmp("count", 32'(count), 32'(sb.size()));
    cmp("ovf", 32'(ovf), 32'(m_ovf));
    cmp("drop_cnt", 32'(drop_cnt), 32'(m_drop8));
    cmp("drop_cnt_cw2", 32'(drop_cnt2), 32'(m_drop2));
    if (sb.size() != 0) cmp("head_data", 32'(out_data), 32'(sb[0]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [7:0] d, input logic rdy);
    req       = r;
    din       = d;
    out_ready = rdy;
    step();
  endtask

  // One low-then-high request cycle pair in mode 00, producing one trigger edge
  task automatic pulse(input logic [7:0] d, input logic rdy);
    apply_stimulus(4'b0000, 8'h00, 1'b0);
    apply_stimulus(4'b0001, d, rdy);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    mode      = 2'b00;
    mask      = 4'b0000;
    req       = 4'b0001;
    din       = 8'h00;
    out_ready = 1'b0;
    model_reset();

    vecs[0]  = '{2'b00, 4'h0, 4'b0001, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[1]  = '{2'b00, 4'h0, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[2]  = '{2'b00, 4'h0, 4'b0001, 8'hA5, 1'b0, 1'b1, 3'd1, 8'hA5};
    vecs[3]  = '{2'b00, 4'h0, 4'b0001, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[4]  = '{2'b01, 4'h0, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[5]  = '{2'b01, 4'h0, 4'b1001, 8'h11, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[6]  = '{2'b01, 4'h0, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[7]  = '{2'b01, 4'h0, 4'b0010, 8'h3C, 1'b0, 1'b1, 3'd1, 8'h3C};
    vecs[8]  = '{2'b01, 4'h0, 4'b0000, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[9]  = '{2'b11, 4'h4, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[10] = '{2'b11, 4'h4, 4'b0100, 8'h77, 1'b0, 1'b1, 3'd1, 8'h77};
    vecs[11] = '{2'b11, 4'h4, 4'b0000, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[12] = '{2'b11, 4'h4, 4'b0010, 8'h88, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[13] = '{2'b11, 4'h4, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};

    #11;
    cmp("reset_valid", 32'(out_valid), 32'd0);
    cmp("reset_count", 32'(count), 32'd0);
    cmp("reset_ovf", 32'(ovf), 32'd0);
    cmp("reset_drop", 32'(drop_cnt), 32'd0);
    #1 rst_n = 1'b1;

    // Trigger modes and the held-through-reset case
    for (int i = 0; i < 14; i++) begin
      mode = vecs[i].mode;
      mask = vecs[i].mask;
      apply_stimulus(vecs[i].req, vecs[i].din, vecs[i].ready);
      cmp($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      cmp($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      if (vecs[i].exp_valid) cmp($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Overflow: five edges into a four-entry FIFO, then drain in order
    mode = 2'b00;
    for (int i = 1; i <= 5; i++) pulse(8'(i), 1'b0);
    cmp("ovf_count", 32'(count), 32'd4);
    cmp("ovf_flag", 32'(ovf), 32'd1);
    cmp("ovf_drop", 32'(drop_cnt), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cmp("drain_data", 32'(out_data), 32'(i));
      apply_stimulus(4'b0000, 8'h00, 1'b1);
    end
    cmp("drain_empty", 32'(out_valid), 32'd0);

    // Full with simultaneous capture and pop, then drain across the pointer wrap
    for (int i = 0; i < 4; i++) pulse(8'h10 + 8'(i), 1'b0);
    apply_stimulus(4'b0000, 8'h00, 1'b0);
    apply_stimulus(4'b0001, 8'h14, 1'b1);
    cmp("cap_pop_count", 32'(count), 32'd4);
    cmp("cap_pop_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(4'b0000, 8'h00, 1'b1);
    cmp("wrap_empty", 32'(count), 32'd0);

    // Saturating narrow drop counter, then clear coinciding with an edge
    for (int i = 0; i < 9; i++) pulse(8'h20 + 8'(i), 1'b0);
    cmp("sat_drop_cw2", 32'(drop_cnt2), 32'd3);
    cmp("sat_drop_cw8", 32'(drop_cnt), 32'd6);
    apply_stimulus(4'b0000, 8'h00, 1'b0);
    clr = 1'b1;
    apply_stimulus(4'b0001, 8'h99, 1'b0);
    clr = 1'b0;
    cmp("clr_count", 32'(count), 32'd0);
    cmp("clr_ovf", 32'(ovf), 32'd0);
    cmp("clr_drop", 32'(drop_cnt), 32'd0);
    apply_stimulus(4'b0001, 8'h9A, 1'b0);
    cmp("clr_held_trig", 32'(count), 32'd0);

    // Asynchronous reset mid-drain, then a held trigger must not capture
    for (int i = 0; i < 4; i++) pulse(8'h40 + 8'(i), 1'b0);
    apply_stimulus(4'b0000, 8'h00, 1'b1);
    cmp("pre_rst_count", 32'(count), 32'd3);
    out_ready = 1'b0;
    req       = 4'b0001;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("async_rst_valid", 32'(out_valid), 32'd0);
    cmp("async_rst_count", 32'(count), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0001, 8'h55, 1'b0);
    cmp("post_rst_held", 32'(count), 32'd0);
    pulse(8'h66, 1'b0);
    cmp("post_rst_cap", 32'(out_data), 32'h66);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
